// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I fetch/decode slice: fetch FSM encoding,
// the canonical NOP and instruction field bit positions.
package rv_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 7;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_W   = 3;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int REG_W      = 5;
  localparam int FUNCT7_BIT = 30;

  // Only the 32-bit encoding space (low two bits set) is supported.
  function automatic logic is_rv32_encoding(input logic [1:0] low_bits);
    return low_bits == 2'b11;
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit RV32I instruction word into the fields used
// by the control unit and register file.
module instr_field_split
  import rv_pkg::*;
(
  input  logic [31:0]         instr,
  output logic [OPCODE_W-1:0] op_code,
  output logic [FUNCT3_W-1:0] funct3,
  output logic                funct7,
  output logic [REG_W-1:0]    rs1,
  output logic [REG_W-1:0]    rs2,
  output logic [REG_W-1:0]    rd
);

  assign op_code = instr[OPCODE_LSB +: OPCODE_W];
  assign rd      = instr[RD_LSB     +: REG_W];
  assign funct3  = instr[FUNCT3_LSB +: FUNCT3_W];
  assign rs1     = instr[RS1_LSB    +: REG_W];
  assign rs2     = instr[RS2_LSB    +: REG_W];
  assign funct7  = instr[FUNCT7_BIT];

  // Only bit 30 of funct7 distinguishes RV32I R-type operations.
  logic unused_funct7_bits;
  assign unused_funct7_bits = ^{instr[31], instr[29:25]};

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-cycle RV32I core: owns the PC, fetches from
// instruction memory with wait states, and presents the decoded instruction.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            IMem_Req,
  output logic [XLEN-1:0] IMem_Addr,
  input  logic            IMem_Ready,
  input  logic [XLEN-1:0] IMem_RData,
  input  logic            Stall,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  output logic [XLEN-1:0] Instr,
  output logic            Instr_Valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [6:0]      OpCode,
  output logic [2:0]      Funct3,
  output logic            Funct7,
  output logic [4:0]      Rs1,
  output logic [4:0]      Rs2,
  output logic [4:0]      Rd,
  output logic            Fault,
  output logic [1:0]      Dbg_State
);

  // Memory handshake: IMem_Req rises with IMem_Addr=PC and both are held
  // unchanged until the first cycle with IMem_Ready=1, in which IMem_RData is
  // taken; IMem_Ready in any other cycle carries no meaning and is ignored.
  fetch_state_t    state;
  logic [XLEN-1:0] next_pc;

  assign PCPlus4   = PC + XLEN'(4);
  assign next_pc   = PCSrc ? (PC + ImmExt) : PCPlus4;
  assign IMem_Addr = PC;
  assign Dbg_State = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_BOOT;
      PC          <= RESET_PC;
      Instr       <= NOP_INSTR;
      IMem_Req    <= 1'b0;
      Instr_Valid <= 1'b0;
      Fault       <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state    <= S_REQ;
          IMem_Req <= 1'b1;
        end
        S_REQ: begin
          if (IMem_Ready) begin
            Instr    <= IMem_RData;
            IMem_Req <= 1'b0;
            if (!is_rv32_encoding(IMem_RData[1:0])) begin
              Fault <= 1'b1;
              state <= S_FAULT;
            end else begin
              Instr_Valid <= 1'b1;
              state       <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          // Branch inputs matter only in the cycle the instruction retires.
          if (!Stall) begin
            Instr_Valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              Fault <= 1'b1;
              state <= S_FAULT;
            end else begin
              PC       <= next_pc;
              IMem_Req <= 1'b1;
              state    <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          IMem_Req    <= 1'b0;
          Instr_Valid <= 1'b0;
        end
        default: begin
          IMem_Req    <= 1'b0;
          Instr_Valid <= 1'b0;
          Fault       <= 1'b1;
          state       <= S_FAULT;
        end
      endcase
    end
  end

  instr_field_split u_field_split (
    .instr   (Instr),
    .op_code (OpCode),
    .funct3  (Funct3),
    .funct7  (Funct7),
    .rs1     (Rs1),
    .rs2     (Rs2),
    .rd      (Rd)
  );

  a_req_valid_exclusive: assert property (
    @(posedge CLK) disable iff (RST) !(IMem_Req && Instr_Valid));

  a_addr_stable_while_waiting: assert property (
    @(posedge CLK) disable iff (RST)
    (IMem_Req && !IMem_Ready) |=> (IMem_Req && IMem_Addr == $past(IMem_Addr)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a memory responder pushes each
// fetched {PC, word} to a queue which is popped when Instr_Valid is seen.
module tb_instr_fetch_unit;
  import rv_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ready;
  logic [31:0] IMem_RData;
  logic        Stall;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] Instr;
  logic        Instr_Valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [6:0]  OpCode;
  logic [2:0]  Funct3;
  logic        Funct7;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [4:0]  Rd;
  logic        Fault;
  logic [1:0]  Dbg_State;

  logic [63:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST(RST), .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
    .IMem_Ready(IMem_Ready), .IMem_RData(IMem_RData), .Stall(Stall),
    .PCSrc(PCSrc), .ImmExt(ImmExt), .Instr(Instr), .Instr_Valid(Instr_Valid),
    .PC(PC), .PCPlus4(PCPlus4), .OpCode(OpCode), .Funct3(Funct3),
    .Funct7(Funct7), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Fault(Fault),
    .Dbg_State(Dbg_State)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST        = 1'b1;
    IMem_Ready = 1'b0;
    IMem_RData = 32'h0;
    Stall      = 1'b0;
    PCSrc      = 1'b0;
    ImmExt     = 32'h0;
    step();
    step();
    RST = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input int waits, input bit expect_exec);
    int n = 0;
    while (IMem_Req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (IMem_Req !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_req_timeout: IMem_Req=%b required 1 for addr %h", IMem_Req, addr);
      return;
    end
    vectors++;
    if (IMem_Addr !== addr) begin
      miscompares++;
      $display("FAIL fetch_addr: got %h required %h", IMem_Addr, addr);
    end
    if (expect_exec) exp_q.push_back({addr, data});
    for (int i = 0; i < waits; i++) begin
      IMem_Ready = 1'b0;
      step();
      vectors++;
      if (IMem_Req !== 1'b1 || IMem_Addr !== addr || Instr_Valid !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_hold: req=%b addr=%h valid=%b required 1/%h/0",
                 IMem_Req, IMem_Addr, Instr_Valid, addr);
      end
    end
    IMem_Ready = 1'b1;
    IMem_RData = data;
    step();
    IMem_Ready = 1'b0;
    IMem_RData = 32'hDEAD_BEEF;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_exec();
    logic [63:0] exp;
    vectors++;
    if (Instr_Valid !== 1'b1) begin
      miscompares++;
      $display("FAIL exec_valid: got %b required 1", Instr_Valid);
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL exec_queue: no expected instruction queued");
      return;
    end
    exp = exp_q.pop_front();
    vectors++;
    if (PC !== exp[63:32]) begin
      miscompares++;
      $display("FAIL exec_pc: got %h required %h", PC, exp[63:32]);
    end
    vectors++;
    if (Instr !== exp[31:0]) begin
      miscompares++;
      $display("FAIL exec_instr: got %h required %h", Instr, exp[31:0]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    vectors++;
    if (IMem_Req !== 1'b0 || Instr_Valid !== 1'b0 || Fault !== 1'b0 || PC !== 32'h0 ||
        Instr !== 32'h13 || OpCode !== 7'h13 || Rd !== 5'd0 || PCPlus4 !== 32'h4) begin
      miscompares++;
      $display("FAIL reset_values: req=%b valid=%b fault=%b pc=%h instr=%h op=%h rd=%0d p4=%h",
               IMem_Req, Instr_Valid, Fault, PC, Instr, OpCode, Rd, PCPlus4);
    end
    step();
    vectors++;
    if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0) begin
      miscompares++;
      $display("FAIL boot_request: req=%b addr=%h required 1/0", IMem_Req, IMem_Addr);
    end
    // reset asserted asynchronously in the middle of a pending request
    #2 RST = 1'b1;
    #1;
    vectors++;
    if (IMem_Req !== 1'b0 || Dbg_State !== S_BOOT) begin
      miscompares++;
      $display("FAIL async_reset: req=%b state=%0d required 0/%0d", IMem_Req, Dbg_State, S_BOOT);
    end
    step();
    RST = 1'b0;
    vectors++;
    if (IMem_Req !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_idle: req=%b required 0", IMem_Req);
    end
    step();
    vectors++;
    if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reboot_request: req=%b addr=%h required 1/0", IMem_Req, IMem_Addr);
    end
  endtask

  task automatic test_sequential();
    do_fetch(32'h0, 32'h0050_0093, 0, 1'b1);
    check_exec();
    vectors++;
    if (OpCode !== 7'h13 || Rd !== 5'd1 || Rs1 !== 5'd0 || Funct3 !== 3'd0 || PCPlus4 !== 32'h4) begin
      miscompares++;
      $display("FAIL seq_fields0: op=%h rd=%0d rs1=%0d f3=%0d p4=%h required 13/1/0/0/4",
               OpCode, Rd, Rs1, Funct3, PCPlus4);
    end
    step();
    vectors++;
    if (Instr_Valid !== 1'b0 || IMem_Req !== 1'b1 || IMem_Addr !== 32'h4) begin
      miscompares++;
      $display("FAIL seq_pulse: valid=%b req=%b addr=%h required 0/1/4", Instr_Valid, IMem_Req, IMem_Addr);
    end
    do_fetch(32'h4, 32'h00A0_0113, 0, 1'b1);
    check_exec();
    vectors++;
    if (OpCode !== 7'h13 || Rd !== 5'd2) begin
      miscompares++;
      $display("FAIL seq_fields1: op=%h rd=%0d required 13/2", OpCode, Rd);
    end
    step();
  endtask

  task automatic test_wait_states();
    do_fetch(32'h8, 32'h0030_0193, 3, 1'b1);
    check_exec();
    step();
    do_fetch(32'hC, NOP_INSTR, $urandom_range(0, 2), 1'b1);
    check_exec();
    step();
  endtask

  task automatic test_branch();
    do_fetch(32'h10, 32'h0000_0063, 0, 1'b1);
    check_exec();
    PCSrc = 1'b1; ImmExt = 32'hFFFF_FFF8;
    step();
    PCSrc = 1'b0; ImmExt = 32'h0;
    vectors++;
    if (IMem_Addr !== 32'h8 || IMem_Req !== 1'b1) begin
      miscompares++;
      $display("FAIL branch_back: addr=%h req=%b required 8/1", IMem_Addr, IMem_Req);
    end
    do_fetch(32'h8, 32'h0000_0063, 0, 1'b1);
    check_exec();
    PCSrc = 1'b1; ImmExt = 32'h8;
    step();
    do_fetch(32'h10, 32'h0000_0063, 0, 1'b1);
    check_exec();
    PCSrc = 1'b1; ImmExt = 32'h0;
    step();
    PCSrc = 1'b0;
    vectors++;
    if (IMem_Addr !== 32'h10 || IMem_Req !== 1'b1) begin
      miscompares++;
      $display("FAIL branch_self: addr=%h req=%b required 10/1", IMem_Addr, IMem_Req);
    end
  endtask

  task automatic test_stall();
    do_fetch(32'h10, 32'h4031_00B3, 0, 1'b1);
    check_exec();
    vectors++;
    if (OpCode !== 7'h33 || Rd !== 5'd1 || Rs1 !== 5'd2 || Rs2 !== 5'd3 || Funct7 !== 1'b1) begin
      miscompares++;
      $display("FAIL rtype_fields: op=%h rd=%0d rs1=%0d rs2=%0d f7=%b required 33/1/2/3/1",
               OpCode, Rd, Rs1, Rs2, Funct7);
    end
    for (int i = 0; i < 4; i++) begin
      Stall = 1'b1; PCSrc = i[0]; ImmExt = 32'h100;
      IMem_Ready = 1'b1; IMem_RData = 32'hFFFF_FFFF;
      step();
      vectors++;
      if (Instr_Valid !== 1'b1 || PC !== 32'h10 || Instr !== 32'h4031_00B3 || IMem_Req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h req=%b", i, Instr_Valid, PC, Instr, IMem_Req);
      end
    end
    Stall = 1'b0; PCSrc = 1'b0; IMem_Ready = 1'b0;
    step();
    vectors++;
    if (IMem_Addr !== 32'h14 || IMem_Req !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: addr=%h req=%b required 14/1", IMem_Addr, IMem_Req);
    end
  endtask

  task automatic test_fault();
    do_fetch(32'h14, NOP_INSTR, 0, 1'b1);
    check_exec();
    PCSrc = 1'b1; ImmExt = 32'h6;
    step();
    PCSrc = 1'b0; ImmExt = 32'h0;
    vectors++;
    if (Fault !== 1'b1 || PC !== 32'h14 || Instr_Valid !== 1'b0 || Dbg_State !== S_FAULT) begin
      miscompares++;
      $display("FAIL misaligned_target: fault=%b pc=%h valid=%b state=%0d required 1/14/0/3",
               Fault, PC, Instr_Valid, Dbg_State);
    end
    IMem_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (IMem_Req !== 1'b0 || Fault !== 1'b1) begin
        miscompares++;
        $display("FAIL fault_sticky[%0d]: req=%b fault=%b required 0/1", i, IMem_Req, Fault);
      end
    end
    apply_reset();
    vectors++;
    if (Fault !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_clear: got %b required 0", Fault);
    end
    do_fetch(32'h0, 32'h0000_0001, 0, 1'b0);
    vectors++;
    if (Fault !== 1'b1 || Instr !== 32'h1 || Instr_Valid !== 1'b0 || IMem_Req !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_encoding: fault=%b instr=%h valid=%b req=%b required 1/1/0/0",
               Fault, Instr, Instr_Valid, IMem_Req);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    do_fetch(32'h0, NOP_INSTR, 0, 1'b1);
    check_exec();
    PCSrc = 1'b1; ImmExt = 32'hFFFF_FFFC;
    step();
    PCSrc = 1'b0; ImmExt = 32'h0;
    do_fetch(32'hFFFF_FFFC, NOP_INSTR, $urandom_range(0, 3), 1'b1);
    check_exec();
    vectors++;
    if (PCPlus4 !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pcplus4: got %h required 0", PCPlus4);
    end
    step();
    vectors++;
    if (IMem_Addr !== 32'h0 || IMem_Req !== 1'b1 || Fault !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_fetch: addr=%h req=%b fault=%b required 0/1/0", IMem_Addr, IMem_Req, Fault);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch();
    test_stall();
    test_fault();
    test_wrap();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
